uart_rx: RTL and testbench

Asynchronous receive engine for the UART peripheral.
- Synchronises UART_RXD and oversamples it at 16x using the baud generator's div16 strobe.
- Deframes 8- or 9-bit frames and pushes them into the two-deep RCREG FIFO.
- Drives the RCSTA status bits FERR, OERR and RX9D, plus the receive-interrupt strobe.
- Sits between the RXD pin / baud generator and the core's RCREG/RCSTA register ports.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Core-side register port of the UART receiver: RCSTA controls, RCREG read
// strobe, FIFO head data and status flags.
interface uart_rx_if;
  logic       rx9;
  logic       cren;
  logic       aden;
  logic       rcreg_rd_en;
  logic [7:0] rcreg_out;
  logic       rx9d;
  logic       ferr;
  logic       oerr;
  logic       rxif_set_en;

  modport master (
    output rx9, cren, aden, rcreg_rd_en,
    input  rcreg_out, rx9d, ferr, oerr, rxif_set_en
  );

  modport slave (
    input  rx9, cren, aden, rcreg_rd_en,
    output rcreg_out, rx9d, ferr, oerr, rxif_set_en
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive engine: synchronises RXD, oversamples at 16x, deframes 8/9-bit
// frames into a two-deep RCREG FIFO and reports FERR/OERR/RX9D status.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     UART_RXD,
  input  logic     rx_tick16,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, BIT9, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rsr_q, rsr_d;
  logic       bit9_q, bit9_d;
  logic       samp7_q, samp7_d;
  logic       samp8_q, samp8_d;
  logic       majority;
  logic       frame_done;

  logic [9:0] mem [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       oerr_q, rxif_q;
  logic [9:0] entry, head;
  logic       accept, push, pop, overrun;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RXD};
  end
  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign majority = (samp7_q & samp8_q) | (samp7_q & rxd_s) | (samp8_q & rxd_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      rsr_q   <= '0;
      bit9_q  <= 1'b0;
      samp7_q <= 1'b1;
      samp8_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      rsr_q   <= rsr_d;
      bit9_q  <= bit9_d;
      samp7_q <= samp7_d;
      samp8_q <= samp8_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    rsr_d      = rsr_q;
    bit9_d     = bit9_q;
    samp7_d    = samp7_q;
    samp8_d    = samp8_q;
    frame_done = 1'b0;
    if (!bus.cren) begin
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else if (rx_tick16) begin
      if (tick_q == 4'd7) samp7_d = rxd_s;
      if (tick_q == 4'd8) samp8_d = rxd_s;
      tick_d = tick_q + 4'd1;
      case (state_q)
        IDLE: begin
          tick_d = '0;
          if (!oerr_q && !rxd_s) begin
            state_d = START;
            tick_d  = 4'd1;
          end
        end
        START: begin
          if (tick_q == 4'd9 && majority) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (tick_q == 4'd15) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (tick_q == 4'd9) rsr_d = {majority, rsr_q[7:1]};
          if (tick_q == 4'd15) begin
            if (bit_q == 3'd7) state_d = bus.rx9 ? BIT9 : STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
        BIT9: begin
          if (tick_q == 4'd9)  bit9_d  = majority;
          if (tick_q == 4'd15) state_d = STOP;
        end
        STOP: begin
          if (tick_q == 4'd9) begin
            frame_done = 1'b1;
            state_d    = IDLE;
            tick_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a frame when the core pops in the same cycle.
  assign entry   = {~majority, bus.rx9 & bit9_q, rsr_q};
  assign accept  = frame_done & ~(bus.rx9 & bus.aden & ~bit9_q);
  assign pop     = bus.rcreg_rd_en & (count_q != 2'd0);
  assign push    = accept & ((count_q != 2'd2) | pop);
  assign overrun = accept & (count_q == 2'd2) & ~pop;

  // NOTE: FIFO storage is not reset; count gates the head so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      oerr_q   <= 1'b0;
      rxif_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (!bus.cren)   oerr_q <= 1'b0;
      else if (overrun) oerr_q <= 1'b1;
      rxif_q <= (count_q != 2'd0);
    end
  end

  assign head            = (count_q != 2'd0) ? mem[rd_ptr_q] : '0;
  assign bus.rcreg_out   = head[7:0];
  assign bus.rx9d        = head[8];
  assign bus.ferr        = head[9];
  assign bus.oerr        = oerr_q;
  assign bus.rxif_set_en = rxif_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected FIFO entries,
// a monitor compares the FIFO head on every core read.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst;
  logic UART_RXD;
  logic rx_tick16;

  uart_rx_if bus ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .UART_RXD  (UART_RXD),
    .rx_tick16 (rx_tick16),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] exp_q [$];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Head entry {ferr, rx9d, data} is compared whenever the core reads a non-empty FIFO.
  always @(negedge clk) begin
    #1;
    if (bus.rcreg_rd_en && bus.rxif_set_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_entry: got %h, expected none",
                 {bus.ferr, bus.rx9d, bus.rcreg_out});
      end else begin
        check("rx_entry", {bus.ferr, bus.rx9d, bus.rcreg_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // One 16x strobe every 4 clocks; optional core read on the same clock.
  task automatic tick(input logic rd);
    repeat (3) @(negedge clk);
    rx_tick16       = 1'b1;
    bus.rcreg_rd_en = rd;
    @(negedge clk);
    rx_tick16       = 1'b0;
    bus.rcreg_rd_en = 1'b0;
  endtask

  task automatic send_bit(input logic v, input int n);
    UART_RXD = v;
    repeat (n) tick(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic nine, input logic b9,
                            input logic stop, input logic rd_at_stop9);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    if (nine) send_bit(b9, 16);
    UART_RXD = stop;
    for (int t = 0; t < 16; t++) tick(rd_at_stop9 && (t == 9));
    UART_RXD = 1'b1;
    repeat (4) tick(1'b0);
  endtask

  task automatic read_fifo();
    int n = 0;
    while (!bus.rxif_set_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rxif_set_en) begin
      check("read_wait_rxif", 10'(bus.rxif_set_en), 10'h001);
    end else begin
      @(negedge clk);
      bus.rcreg_rd_en = 1'b1;
      @(negedge clk);
      bus.rcreg_rd_en = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    UART_RXD        = 1'b1;
    rx_tick16       = 1'b0;
    bus.rx9         = 1'b0;
    bus.cren        = 1'b0;
    bus.aden        = 1'b0;
    bus.rcreg_rd_en = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_rxif", 10'(bus.rxif_set_en), 10'h000);
    check("reset_head", {bus.ferr, bus.rx9d, bus.rcreg_out}, 10'h000);
    check("reset_oerr", 10'(bus.oerr), 10'h000);
    rst      = 1'b0;
    bus.cren = 1'b1;
    repeat (2) @(negedge clk);

    // 8-bit frame
    exp_q.push_back(10'h0A5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_rxif", 10'(bus.rxif_set_en), 10'h001);
    read_fifo();
    settle();
    check("t1_rxif_empty", 10'(bus.rxif_set_en), 10'h000);
    check("t1_out_empty", 10'(bus.rcreg_out), 10'h000);

    // 9-bit address detect: bit9=0 frame discarded
    bus.rx9  = 1'b1;
    bus.aden = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    check("t2_discard", 10'(bus.rxif_set_en), 10'h000);
    exp_q.push_back(10'h17E);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b1, 1'b0);
    read_fifo();
    settle();
    check("t2_count1", 10'(bus.rxif_set_en), 10'h000);
    bus.rx9  = 1'b0;
    bus.aden = 1'b0;

    // framing error, then recovery
    exp_q.push_back(10'h281);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 16);
    check("t3_ferr", 10'(bus.ferr), 10'h001);
    read_fifo();
    exp_q.push_back(10'h012);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    read_fifo();

    // overrun
    exp_q.push_back(10'h011);
    exp_q.push_back(10'h022);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_oerr_set", 10'(bus.oerr), 10'h001);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_oerr_sticky", 10'(bus.oerr), 10'h001);
    bus.cren = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_oerr_clear", 10'(bus.oerr), 10'h000);
    check("t4_fifo_kept", 10'(bus.rxif_set_en), 10'h001);
    bus.cren = 1'b1;
    read_fifo();
    exp_q.push_back(10'h044);
    send_frame(8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    read_fifo();
    read_fifo();
    settle();
    check("t4_empty", 10'(bus.rxif_set_en), 10'h000);

    // false start glitch
    UART_RXD = 1'b0;
    repeat (4) tick(1'b0);
    UART_RXD = 1'b1;
    repeat (20) tick(1'b0);
    check("t5_glitch", 10'(bus.rxif_set_en), 10'h000);

    // push and pop on the same clock with the FIFO full
    exp_q.push_back(10'h066);
    exp_q.push_back(10'h077);
    exp_q.push_back(10'h088);
    send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h88, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_no_oerr", 10'(bus.oerr), 10'h000);
    check("t5_head_77", {bus.ferr, bus.rx9d, bus.rcreg_out}, 10'h077);
    read_fifo();
    read_fifo();
    settle();
    check("t5_empty", 10'(bus.rxif_set_en), 10'h000);

    // cren abort during data bit 3
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    send_bit(1'b0, 8);
    bus.cren = 1'b0;
    repeat (3) @(negedge clk);
    bus.cren = 1'b1;
    send_bit(1'b1, 32);
    check("t6_abort", 10'(bus.rxif_set_en), 10'h000);
    exp_q.push_back(10'h05A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    read_fifo();

    // reset mid-frame flushes the FIFO
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 16);
    check("t6_pre_rst", {bus.ferr, bus.rx9d, bus.rcreg_out}, 10'h299);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    UART_RXD = 1'b1;
    settle();
    check("t6_rst_rxif", 10'(bus.rxif_set_en), 10'h000);
    check("t6_rst_head", {bus.ferr, bus.rx9d, bus.rcreg_out}, 10'h000);
    check("t6_rst_oerr", 10'(bus.oerr), 10'h000);
    repeat (20) tick(1'b0);
    exp_q.push_back(10'h0C3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    read_fifo();
    settle();
    check("sb_drained", 10'(exp_q.size()), 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
